// File: rtl/fwd_tracker_pkg.sv
// rtl/fwd_tracker_pkg.sv - entry type and selector encoding shared by the forwarding tracker
package fwd_tracker_pkg;

  // Widest register index an entry can hold; narrower REG_W values are zero-extended.
  localparam int TRK_RD_W       = 8;
  localparam int TRK_DEF_STAGES = 3;

  localparam int SEL_REGFILE = 0;
  localparam int SEL_BUF     = TRK_DEF_STAGES + 1;

  typedef struct packed {
    logic                valid;
    logic [TRK_RD_W-1:0] rd;
    logic                write_rd;
    logic                is_load;
  } tracker_entry_t;

  // Search position p (slots first, buffer at p == NUM_STAGES) maps to selector p+1.
  function automatic int sel_for_slot(input int slot);
    return slot + 1;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - youngest-first producer search and load-use check for one source operand
module fwd_match
  import fwd_tracker_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_W      = 5,
  parameter int LOAD_STAGE = 1,
  parameter int SW         = $clog2(NUM_STAGES + 2)
) (
  input  tracker_entry_t   entries_i [NUM_STAGES+1],
  input  logic             src_valid_i,
  input  logic [REG_W-1:0] src_reg_i,
  input  logic             load_ready_i,
  output logic [SW-1:0]    sel_o,
  output logic             stall_o
);

  logic [TRK_RD_W-1:0] src_rd;
  logic                found;

  assign src_rd = TRK_RD_W'(src_reg_i);

  always_comb begin
    found   = 1'b0;
    sel_o   = SW'(SEL_REGFILE);
    stall_o = 1'b0;
    if (src_valid_i && (src_rd != '0)) begin
      for (int p = 0; p <= NUM_STAGES; p++) begin
        if (!found && entries_i[p].valid && entries_i[p].write_rd &&
            (entries_i[p].rd == src_rd)) begin
          found   = 1'b1;
          sel_o   = SW'(sel_for_slot(p));
          stall_o = entries_i[p].is_load &&
                    ((p < LOAD_STAGE) || ((p == LOAD_STAGE) && !load_ready_i));
        end
      end
    end
  end

endmodule

// File: rtl/operand_forward_tracker.sv
// rtl/operand_forward_tracker.sv - in-flight destination tracker producing forwarding selects and load-use stall
module operand_forward_tracker
  import fwd_tracker_pkg::*;
#(
  parameter int  NUM_STAGES   = 3,
  parameter int  NUM_SRC      = 2,
  parameter int  REG_W        = 5,
  parameter int  LOAD_STAGE   = 1,
  parameter int  FLUSH_STAGES = 1,
  localparam int SW           = $clog2(NUM_STAGES + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid_i,
  input  logic [REG_W-1:0]         issue_rd_i,
  input  logic                     issue_write_rd_i,
  input  logic                     issue_is_load_i,
  input  logic [NUM_SRC-1:0]       src_valid_i,
  input  logic [NUM_SRC*REG_W-1:0] src_reg_i,
  input  logic                     load_ready_i,
  input  logic                     stall_in_i,
  input  logic                     flush_i,
  output logic                     stall_out_o,
  output logic                     out_valid_o,
  output logic [NUM_SRC*SW-1:0]    fwd_sel_o,
  output logic [SW-1:0]            inflight_count_o
);

  tracker_entry_t            slots_q [NUM_STAGES];
  tracker_entry_t            slots_d [NUM_STAGES];
  tracker_entry_t            buf_q, buf_d;
  tracker_entry_t            entries [NUM_STAGES+1];
  tracker_entry_t            issued;
  logic                      out_valid_q, out_valid_d;
  logic [NUM_SRC*SW-1:0]     fwd_sel_q, fwd_sel_d, match_sel;
  logic [NUM_SRC-1:0]        src_stall;
  logic                      accept;
  logic [SW-1:0]             count;

  always_comb begin
    for (int s = 0; s < NUM_STAGES; s++) entries[s] = slots_q[s];
    entries[NUM_STAGES] = buf_q;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .NUM_STAGES(NUM_STAGES),
      .REG_W     (REG_W),
      .LOAD_STAGE(LOAD_STAGE),
      .SW        (SW)
    ) u_match (
      .entries_i   (entries),
      .src_valid_i (src_valid_i[i]),
      .src_reg_i   (src_reg_i[i*REG_W +: REG_W]),
      .load_ready_i(load_ready_i),
      .sel_o       (match_sel[i*SW +: SW]),
      .stall_o     (src_stall[i])
    );
  end

  assign stall_out_o = issue_valid_i && ((|src_stall) || stall_in_i);
  assign accept      = issue_valid_i && !stall_out_o && !stall_in_i && !flush_i;

  always_comb begin
    issued          = '0;
    issued.valid    = 1'b1;
    issued.rd       = TRK_RD_W'(issue_rd_i);
    issued.write_rd = issue_write_rd_i;
    issued.is_load  = issue_is_load_i;
  end

  always_comb begin
    slots_d     = slots_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    fwd_sel_d   = fwd_sel_q;
    if (stall_in_i) begin
      // Only the oldest slot drains into the retire buffer; a latched "oldest slot" select follows it there.
      if (slots_q[NUM_STAGES-1].valid) buf_d = slots_q[NUM_STAGES-1];
      slots_d[NUM_STAGES-1] = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (fwd_sel_q[i*SW +: SW] == SW'(NUM_STAGES)) fwd_sel_d[i*SW +: SW] = SW'(NUM_STAGES + 1);
      end
    end else begin
      for (int s = NUM_STAGES - 1; s > 0; s--) slots_d[s] = slots_q[s-1];
      if (accept) slots_d[0] = issued;
      else        slots_d[0] = '0;
      out_valid_d = accept;
      fwd_sel_d   = accept ? match_sel : '0;
    end
    if (flush_i) begin
      for (int s = 0; s < FLUSH_STAGES; s++) slots_d[s] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_STAGES; s++) slots_q[s] <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      fwd_sel_q   <= '0;
    end else begin
      slots_q     <= slots_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      fwd_sel_q   <= fwd_sel_d;
    end
  end

  always_comb begin
    count = '0;
    for (int p = 0; p <= NUM_STAGES; p++) begin
      if (entries[p].valid && entries[p].write_rd) count = count + SW'(1);
    end
  end

  assign out_valid_o      = out_valid_q;
  assign fwd_sel_o        = fwd_sel_q;
  assign inflight_count_o = count;

endmodule

// File: tb/tb_operand_forward_tracker.sv
// tb/tb_operand_forward_tracker.sv - directed vector bench for operand_forward_tracker
module tb_operand_forward_tracker;

  logic       clk;
  logic       rst;
  logic       issue_valid_i;
  logic [4:0] issue_rd_i;
  logic       issue_write_rd_i;
  logic       issue_is_load_i;
  logic [1:0] src_valid_i;
  logic [9:0] src_reg_i;
  logic       load_ready_i;
  logic       stall_in_i;
  logic       flush_i;
  logic       stall_out_o;
  logic       out_valid_o;
  logic [5:0] fwd_sel_o;
  logic [2:0] inflight_count_o;

  int n_cmp = 0;
  int n_bad = 0;

  operand_forward_tracker dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_i      (issue_rd_i),
    .issue_write_rd_i(issue_write_rd_i),
    .issue_is_load_i (issue_is_load_i),
    .src_valid_i     (src_valid_i),
    .src_reg_i       (src_reg_i),
    .load_ready_i    (load_ready_i),
    .stall_in_i      (stall_in_i),
    .flush_i         (flush_i),
    .stall_out_o     (stall_out_o),
    .out_valid_o     (out_valid_o),
    .fwd_sel_o       (fwd_sel_o),
    .inflight_count_o(inflight_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic [1:0] sv;
    logic [4:0] s0;
    logic [4:0] s1;
    logic       lr;
    logic       si;
    logic       fl;
    logic       e_stall;
    logic       e_ov;
    logic [2:0] e_sel0;
    logic [2:0] e_sel1;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(input int iv, input int rd, input int wr, input int ld,
                              input int sv, input int s0, input int s1, input int lr,
                              input int si, input int fl, input int e_stall, input int e_ov,
                              input int e_sel0, input int e_sel1, input int e_cnt);
    vec_t v;
    v.iv = 1'(iv);  v.rd = 5'(rd);  v.wr = 1'(wr);  v.ld = 1'(ld);
    v.sv = 2'(sv);  v.s0 = 5'(s0);  v.s1 = 5'(s1);  v.lr = 1'(lr);
    v.si = 1'(si);  v.fl = 1'(fl);
    v.e_stall = 1'(e_stall);  v.e_ov = 1'(e_ov);
    v.e_sel0 = 3'(e_sel0);  v.e_sel1 = 3'(e_sel1);  v.e_cnt = 3'(e_cnt);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid_i    = v.iv;
    issue_rd_i       = v.rd;
    issue_write_rd_i = v.wr;
    issue_is_load_i  = v.ld;
    src_valid_i      = v.sv;
    src_reg_i        = {v.s1, v.s0};
    load_ready_i     = v.lr;
    stall_in_i       = v.si;
    flush_i          = v.fl;
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #1;
    check({tag, " stall_out"}, 32'(stall_out_o), 32'(v.e_stall));
    @(posedge clk);
    #1;
    check({tag, " out_valid"}, 32'(out_valid_o), 32'(v.e_ov));
    check({tag, " sel0"}, 32'(fwd_sel_o[2:0]), 32'(v.e_sel0));
    check({tag, " sel1"}, 32'(fwd_sel_o[5:3]), 32'(v.e_sel1));
    check({tag, " inflight"}, 32'(inflight_count_o), 32'(v.e_cnt));
  endtask

  initial begin
    //                iv rd wr ld sv s0  s1 lr si fl  stall ov sel0 sel1 cnt
    vecs[0]  = mk(1,  5, 1, 0, 0,  0,  0, 0, 0, 0,  0, 1, 0, 0, 1);
    vecs[1]  = mk(1, 10, 1, 0, 3,  6,  7, 0, 0, 0,  0, 1, 0, 0, 2);
    vecs[2]  = mk(1, 12, 1, 0, 0,  0,  0, 0, 0, 0,  0, 1, 0, 0, 3);
    vecs[3]  = mk(1,  0, 0, 0, 3, 12,  5, 0, 0, 0,  0, 1, 1, 3, 2);
    vecs[4]  = mk(1,  8, 1, 1, 0,  0,  0, 0, 0, 0,  0, 1, 0, 0, 2);
    vecs[5]  = mk(1, 13, 1, 0, 1,  8,  0, 0, 0, 0,  1, 0, 0, 0, 1);
    vecs[6]  = mk(1, 13, 1, 0, 1,  8,  0, 1, 0, 0,  0, 1, 2, 0, 2);
    vecs[7]  = mk(1, 14, 1, 1, 0,  0,  0, 0, 0, 0,  0, 1, 0, 0, 2);
    vecs[8]  = mk(1, 15, 1, 0, 3, 14, 13, 0, 0, 0,  1, 0, 0, 0, 2);
    vecs[9]  = mk(1, 15, 1, 0, 3, 14, 13, 0, 0, 0,  1, 0, 0, 0, 1);
    vecs[10] = mk(1, 15, 1, 0, 3, 14, 13, 0, 0, 0,  0, 1, 3, 0, 1);
    vecs[11] = mk(1,  9, 1, 0, 0,  0,  0, 0, 0, 0,  0, 1, 0, 0, 2);
    vecs[12] = mk(0,  0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 0, 0, 2);
    vecs[13] = mk(1,  0, 0, 0, 3, 15,  9, 0, 0, 0,  0, 1, 3, 2, 1);
    vecs[14] = mk(0,  0, 0, 0, 0,  0,  0, 0, 1, 0,  0, 1, 4, 2, 1);
    vecs[15] = mk(1, 17, 1, 0, 1,  9,  0, 0, 1, 0,  1, 1, 4, 2, 1);
    vecs[16] = mk(1, 17, 1, 0, 3,  9,  0, 0, 0, 0,  0, 1, 4, 0, 2);
    vecs[17] = mk(1,  3, 1, 0, 0,  0,  0, 0, 0, 1,  0, 0, 0, 0, 2);
    vecs[18] = mk(0,  0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 0, 0, 2);
    vecs[19] = mk(0,  0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 0, 0, 1);
    vecs[20] = mk(1,  3, 1, 0, 0,  0,  0, 0, 0, 0,  0, 1, 0, 0, 2);
    vecs[21] = mk(0,  0, 0, 0, 0,  0,  0, 0, 1, 1,  0, 1, 0, 0, 1);
    vecs[22] = mk(1, 19, 1, 0, 3,  3,  9, 0, 0, 0,  0, 1, 0, 4, 2);

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset stall_out", 32'(stall_out_o), 32'd0);
    check("reset out_valid", 32'(out_valid_o), 32'd0);
    check("reset fwd_sel", 32'(fwd_sel_o), 32'd0);
    check("reset inflight", 32'(inflight_count_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) apply(vecs[i], $sformatf("v%0d", i));

    // Reset while stalled with a valid retire buffer (holding x9) and a nonzero latched select.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_stall out_valid", 32'(out_valid_o), 32'd0);
    check("rst_stall fwd_sel", 32'(fwd_sel_o), 32'd0);
    check("rst_stall inflight", 32'(inflight_count_o), 32'd0);
    rst = 1'b0;
    apply(mk(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 1, 0, 0, 0), "post_rst x9 read");

    // Older load and younger ALU writer of x5: the younger one wins and no stall results.
    apply(mk(1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), "ywin load x5");
    apply(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2), "ywin alu x5");
    apply(mk(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 1, 1, 0, 2), "ywin read x5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_forward_tracker.md
# operand_forward_tracker

Parametrised hazard and forwarding tracker for the decode stage. It records every in-flight destination register across NUM_STAGES downstream slots plus a one-entry retire buffer. For each of NUM_SRC source operands it produces a registered forwarding selector and a combinational load-use stall. It replaces the fixed two-operand, three-stage forwarding/stall logic inside decode, and adds a configurable depth, load-ready stage, flush depth and operand count.

## Interface
- NUM_STAGES, 3: tracked slots after decode (slot 0 = EX).
- NUM_SRC, 2: source operands per instruction.
- REG_W, 5: register index width.
- LOAD_STAGE, 1: slot at which load data may be ready.
- FLUSH_STAGES, 1: youngest slots cleared on flush (1..NUM_STAGES).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- issue_valid  in  1  decode holds a valid instruction.
- issue_rd  in  REG_W  destination register.
- issue_write_rd  in  1  instruction writes rd.
- issue_is_load  in  1  rd result comes from memory.
- src_valid  in  NUM_SRC  source i is a register read.
- src_reg  in  NUM_SRC*REG_W  source register indices; source i occupies bits [i*REG_W +: REG_W].
- load_ready  in  1  the load in slot LOAD_STAGE has data this cycle.
- stall_in  in  1  downstream stall.
- flush  in  1  branch reset.
- stall_out  out  1  combinational; decode must hold.
- out_valid  out  1  registered; the instruction was accepted.
- fwd_sel  out  NUM_SRC*SW  registered selector, with SW = $clog2(NUM_STAGES+2). Encoding: 0 = register file, s+1 = slot s, NUM_STAGES+1 = retire buffer.
- inflight_count  out  $clog2(NUM_STAGES+2)  valid writing entries, buffer included.

## Operation
- Each slot and the buffer hold {valid, rd, write_rd, is_load}. An entry counts as a producer only if valid && write_rd && rd != 0.
- accept = issue_valid && !stall_out && !stall_in && !flush.
- Source match for each i with src_valid[i] and src_reg[i] != 0:
  - Search youngest first: slot 0, slot 1, …, slot NUM_STAGES-1, then the buffer.
  - The first producer with equal rd wins. No match gives sel 0.
- Per-source stall is raised when the winning producer is a load and either:
  - its slot < LOAD_STAGE, or
  - its slot == LOAD_STAGE and load_ready is low.
- stall_out = issue_valid && (any per-source stall || stall_in).
- Advance when !stall_in:
  - Slots shift: slot s+1 <= slot s.
  - Slot 0 <= the issued entry if accept, else a bubble.
  - The buffer holds.
- Downstream stall when stall_in:
  - Slots 0..NUM_STAGES-2 hold.
  - If slot NUM_STAGES-1 is valid, the buffer <= slot NUM_STAGES-1.
  - Slot NUM_STAGES-1 is then cleared.
- Flush (not stalled):
  - Slots 0..FLUSH_STAGES-1 are cleared after the shift.
  - The issuing instruction is not accepted.
  - Older slots and the buffer are unaffected.
- fwd_sel and out_valid:
  - On !stall_in: out_valid <= accept, and fwd_sel <= the match result when accept, else 0.
  - On stall_in, aging: each sel equal to NUM_STAGES becomes NUM_STAGES+1. All other values hold.
- The buffer is overwritten only by a retire on stall. It is never cleared except by rst.

## Timing
- Reset values: all slots and buffer invalid; out_valid 0; fwd_sel all 0; inflight_count 0.
- stall_out has zero latency from all inputs. fwd_sel and out_valid have one-cycle latency.
- flush together with stall_in: stall_in takes priority for the shift, and the flush clears slots 0..FLUSH_STAGES-1 in place.
- An entry is visible to matching in the cycle after it is accepted.
- Back-to-back writers to the same rd: the youngest wins.
- rst takes precedence over everything, including mid-stall.

## Structure
- Put the shared package fwd_tracker_pkg in the instruction_decode_types neighbourhood. It contains:
  - the tracker_entry_t struct;
  - the selector encoding constants SEL_REGFILE and SEL_BUF;
  - the sel_for_slot function.
- One sub-module, fwd_match, instantiated per source. It takes the entries and a register index and returns {sel, stall}; it is purely combinational.

## Test plan
- Independent operands: ADD x5 issued, next instruction reads x6,x7 -> stall_out 0, fwd_sel {0,0}, out_valid 1.
- ALU back-to-back: write x5, then read x5 as src0 -> fwd_sel[0]=1, no stall. Two cycles later, an instruction reading x5 gets sel 3.
- Load-use, LOAD_STAGE=1:
  - Load x8, then read x8 -> stall_out for 1 cycle (slot 0).
  - Next cycle: load_ready=0 -> stall persists; load_ready=1 -> accept with sel 2.
- Downstream stall aging: writer of x9 in slot 2, consumer latched with sel 3; stall_in=1 -> buffer holds x9, fwd_sel becomes 4, and holds at 4 while the stall continues.
- Flush: writer of x3 in slot 0, flush=1 -> slot 0 cleared. A subsequent reader of x3 gets sel 0, and inflight_count drops by 1.
- Reset mid-stall: with stall_in=1 and buffer valid, rst -> all outputs 0 and the buffer invalid next cycle.
